// File: rtl/branch_predictor_bht_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht_if
// Purpose : Bundles the lookup, resolve, redirect and statistics signals that
//           run between the branch unit pipeline and the bimodal predictor.
// Signals : lk_valid/lk_pc            lookup request (IF/DEC)
//           lk_taken                  prediction returned to the lookup stage
//           rs_valid/rs_pc/rs_pred_taken/rs_actual/rs_target
//                                     resolved conditional branch from EXE
//           flush/redirect_pc         mispredict recovery towards the front end
//           n_branches/n_mispredicts  saturating performance counters
// Modports: master = pipeline side (drives lookup/resolve)
//           slave  = predictor side (drives prediction/flush/stats)
// -----------------------------------------------------------------------------
interface branch_predictor_bht_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic              lk_valid;
    logic [XLEN-1:0]   lk_pc;
    logic              lk_taken;

    logic              rs_valid;
    logic [XLEN-1:0]   rs_pc;
    logic              rs_pred_taken;
    logic              rs_actual;
    logic [XLEN-1:0]   rs_target;

    logic              flush;
    logic [XLEN-1:0]   redirect_pc;

    logic [STAT_W-1:0] n_branches;
    logic [STAT_W-1:0] n_mispredicts;

    modport master (
        output lk_valid, lk_pc,
        output rs_valid, rs_pc, rs_pred_taken, rs_actual, rs_target,
        input  lk_taken, flush, redirect_pc, n_branches, n_mispredicts
    );

    modport slave (
        input  lk_valid, lk_pc,
        input  rs_valid, rs_pc, rs_pred_taken, rs_actual, rs_target,
        output lk_taken, flush, redirect_pc, n_branches, n_mispredicts
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
// Purpose : Bimodal branch predictor. A PC-indexed table of saturating counters
//           predicts conditional branches at lookup and is trained by resolved
//           outcomes from EXE. A mispredict raises flush and supplies the
//           correct next PC in the same cycle. Two saturating performance
//           counters track resolved branches and mispredicts.
// Ports   : Clock   rising-edge clock
//           nReset  asynchronous, active-low reset
//           bus     branch_predictor_bht_if.slave (lookup, resolve, flush,
//                   redirect, statistics). The interface XLEN/STAT_W must match
//                   the parameters of this module.
// Params  : XLEN, BHT_ENTRIES (power of two >= 2), CTR_BITS (1..3), INIT_CTR,
//           PC_LSB, STAT_W, MODE (0 = static not-taken, 1 = bimodal)
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int INIT_CTR    = 1,
    parameter int PC_LSB      = 2,
    parameter int STAT_W      = 32,
    parameter int MODE        = 1
) (
    input  logic                  Clock,
    input  logic                  nReset,
    branch_predictor_bht_if.slave bus
);

    localparam int                   IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'(INIT_CTR);
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_ONE  = CTR_BITS'(1);
    localparam logic [STAT_W-1:0]    STAT_MAX = '1;
    localparam logic [STAT_W-1:0]    STAT_ONE = STAT_W'(1);
    localparam logic [XLEN-1:0]      PC_STEP  = XLEN'(4);

    logic [CTR_BITS-1:0] ctrTable [BHT_ENTRIES];

    logic [IDX_W-1:0]    lkIdx;
    logic [IDX_W-1:0]    rsIdx;
    logic [CTR_BITS-1:0] rsCtr;
    logic [CTR_BITS-1:0] rsCtrNext;
    logic                mispredict;
    logic [STAT_W-1:0]   nBranches;
    logic [STAT_W-1:0]   nMispredicts;

    // Only the index slice of the lookup PC matters; the rest is intentionally
    // ignored (no tags, aliasing is accepted).
    logic                unusedLkPcBits;
    assign unusedLkPcBits = ^bus.lk_pc;

    assign lkIdx = bus.lk_pc[PC_LSB +: IDX_W];
    assign rsIdx = bus.rs_pc[PC_LSB +: IDX_W];
    assign rsCtr = ctrTable[rsIdx];

    // Lookup reads the registered table, so a resolve to the same entry in the
    // same cycle is not visible until the following cycle.
    assign bus.lk_taken = bus.lk_valid && (MODE == 1) && ctrTable[lkIdx][CTR_BITS-1];

    assign mispredict = bus.rs_valid && (bus.rs_pred_taken ^ bus.rs_actual);
    assign bus.flush  = mispredict;

    // Recovery PC is only driven while flushing so the bus is quiet otherwise.
    // The fall-through add wraps at XLEN.
    always_comb begin
        bus.redirect_pc = '0;
        if (mispredict) begin
            bus.redirect_pc = bus.rs_actual ? bus.rs_target : (bus.rs_pc + PC_STEP);
        end
    end

    // Saturating step of the resolved entry: never wraps past 0 or all-ones.
    always_comb begin
        rsCtrNext = rsCtr;
        if (bus.rs_actual) begin
            if (rsCtr != CTR_MAX) begin
                rsCtrNext = rsCtr + CTR_ONE;
            end
        end else begin
            if (rsCtr != '0) begin
                rsCtrNext = rsCtr - CTR_ONE;
            end
        end
    end

    // Counter table: reset forces every entry back to the initial bias and any
    // resolve in flight during reset is dropped.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctrTable[i] <= CTR_INIT;
            end
        end else if (bus.rs_valid) begin
            ctrTable[rsIdx] <= rsCtrNext;
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            nBranches    <= '0;
            nMispredicts <= '0;
        end else if (bus.rs_valid) begin
            if (nBranches != STAT_MAX) begin
                nBranches <= nBranches + STAT_ONE;
            end
            if (mispredict && (nMispredicts != STAT_MAX)) begin
                nMispredicts <= nMispredicts + STAT_ONE;
            end
        end
    end

    assign bus.n_branches    = nBranches;
    assign bus.n_mispredicts = nMispredicts;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
// Purpose : Directed self-checking bench for branch_predictor_bht. A bimodal
//           instance and a static (MODE=0) instance see identical stimulus.
//           Expected outputs come from a small reference model of the counter
//           table and statistics, pushed to a queue when stimulus is applied
//           and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

    logic Clock;
    logic nReset;

    branch_predictor_bht_if #(.XLEN(32), .STAT_W(32)) bpBus ();
    branch_predictor_bht_if #(.XLEN(32), .STAT_W(32)) staticBus ();

    branch_predictor_bht #(.MODE(1)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bpBus.slave)
    );

    branch_predictor_bht #(.MODE(0)) dutStatic (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (staticBus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        string       tag;
        logic        lkTaken;
        logic        flush;
        logic [31:0] redirect;
        logic [31:0] nBr;
        logic [31:0] nMis;
    } expT;

    expT expQ[$];

    int compared   = 0;
    int mismatched = 0;

    int          modelCtr [64];
    int unsigned modelBr;
    int unsigned modelMis;

    task automatic modelReset();
        for (int i = 0; i < 64; i++) modelCtr[i] = 1;
        modelBr  = 0;
        modelMis = 0;
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic bit predOf(input logic [31:0] pc);
        return modelCtr[idxOf(pc)] >= 2;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic driveBoth(input bit lkV, input logic [31:0] lkPc, input bit rsV,
                             input logic [31:0] rsPc, input bit pred, input bit act,
                             input logic [31:0] tgt);
        bpBus.lk_valid          = lkV;
        bpBus.lk_pc             = lkPc;
        bpBus.rs_valid          = rsV;
        bpBus.rs_pc             = rsPc;
        bpBus.rs_pred_taken     = pred;
        bpBus.rs_actual         = act;
        bpBus.rs_target         = tgt;
        staticBus.lk_valid      = lkV;
        staticBus.lk_pc         = lkPc;
        staticBus.rs_valid      = rsV;
        staticBus.rs_pc         = rsPc;
        staticBus.rs_pred_taken = pred;
        staticBus.rs_actual     = act;
        staticBus.rs_target     = tgt;
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected
    // outputs; the model then advances as the DUT will at the next rising edge.
    task automatic applyStimulus(input string tag, input bit lkV, input logic [31:0] lkPc,
                                 input bit rsV, input logic [31:0] rsPc, input bit pred,
                                 input bit act, input logic [31:0] tgt);
        expT e;
        bit  misp;
        int  ri;
        @(negedge Clock);
        driveBoth(lkV, lkPc, rsV, rsPc, pred, act, tgt);
        misp       = rsV && (pred != act);
        e.tag      = tag;
        e.lkTaken  = lkV && (modelCtr[idxOf(lkPc)] >= 2);
        e.flush    = misp;
        e.redirect = misp ? (act ? tgt : rsPc + 32'd4) : 32'd0;
        e.nBr      = modelBr;
        e.nMis     = modelMis;
        expQ.push_back(e);
        if (rsV) begin
            ri = idxOf(rsPc);
            if (act && modelCtr[ri] < 3) modelCtr[ri]++;
            if (!act && modelCtr[ri] > 0) modelCtr[ri]--;
            if (modelBr != 32'hFFFF_FFFF) modelBr++;
            if (misp && modelMis != 32'hFFFF_FFFF) modelMis++;
        end
    endtask

    task automatic checkOutput();
        expT e;
        #2;
        e = expQ.pop_front();
        checkVal({e.tag, ".lk_taken"},    32'(bpBus.lk_taken),     32'(e.lkTaken));
        checkVal({e.tag, ".flush"},       32'(bpBus.flush),        32'(e.flush));
        checkVal({e.tag, ".redirect_pc"}, bpBus.redirect_pc,       e.redirect);
        checkVal({e.tag, ".n_branches"},  bpBus.n_branches,        e.nBr);
        checkVal({e.tag, ".n_mispred"},   bpBus.n_mispredicts,     e.nMis);
        checkVal({e.tag, ".static_lk"},   32'(staticBus.lk_taken), 32'd0);
        checkVal({e.tag, ".static_fl"},   32'(staticBus.flush),    32'(e.flush));
    endtask

    task automatic step(input string tag, input bit lkV, input logic [31:0] lkPc,
                        input bit rsV, input logic [31:0] rsPc, input bit pred,
                        input bit act, input logic [31:0] tgt);
        applyStimulus(tag, lkV, lkPc, rsV, rsPc, pred, act, tgt);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pc;
        bit          act;
        bit          pred;

        nReset = 1'b0;
        driveBoth(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        modelReset();
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        $display("[TB] reset released");

        checkVal("reset.n_branches", bpBus.n_branches,    32'd0);
        checkVal("reset.n_mispred",  bpBus.n_mispredicts, 32'd0);

        // Post-reset lookup and quiet bus
        step("t1_lookup", 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
        step("t1_idle",   0, 32'h0,   0, 32'h0, 0, 0, 32'h0);

        // Training: two taken resolves predicted not-taken
        step("t2_train1", 0, 32'h0,   1, 32'h100, 0, 1, 32'h180);
        step("t2_train2", 1, 32'h100, 1, 32'h100, 0, 1, 32'h180);
        step("t2_look",   1, 32'h100, 0, 32'h0,   0, 0, 32'h0);

        // Saturation at the top, then one step down
        for (int i = 0; i < 5; i++)
            step("t3_taken", 1, 32'h40, 1, 32'h40, predOf(32'h40), 1, 32'h90);
        step("t3_nt",    1, 32'h40, 1, 32'h40, 1, 0, 32'h90);
        step("t3_after", 1, 32'h40, 0, 32'h0,  0, 0, 32'h0);

        // Same-cycle lookup and resolve to one entry reads the old value
        step("t4_same", 1, 32'h20, 1, 32'h20, 0, 1, 32'h60);
        step("t4_next", 1, 32'h20, 0, 32'h0,  0, 0, 32'h0);

        // Aliasing between 0x000 and 0x100, saturation at the bottom, PC wrap
        step("t5_alias", 1, 32'h000, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            step("t5_nt", 0, 32'h0, 1, 32'h000, predOf(32'h000), 0, 32'h10);
        step("t5_taken", 0, 32'h0,   1, 32'h100, 0, 1, 32'h10);
        step("t5_look",  1, 32'h100, 0, 32'h0,   0, 0, 32'h0);
        step("t5_wrap",  0, 32'h0,   1, 32'hFFFF_FFFC, 1, 0, 32'h1234);

        // Statistics: fresh reset, ten resolves with three mispredicts
        @(negedge Clock);
        nReset = 1'b0;
        driveBoth(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        modelReset();
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc   = $urandom & 32'hFFFF_FFFC;
            act  = 1'($urandom_range(0, 1));
            pred = ((i % 3) == 2) ? !act : act;
            step("t6_res", 0, 32'h0, 1, pc, pred, act, pc + 32'h40);
        end
        step("t6_train1", 0, 32'h0,  1, 32'h80, predOf(32'h80), 1, 32'hC0);
        step("t6_train2", 0, 32'h0,  1, 32'h80, predOf(32'h80), 1, 32'hC0);
        step("t6_pre",    1, 32'h80, 0, 32'h0,  0, 0, 32'h0);

        // Mid-stream async reset with a resolve held across a clock edge
        @(negedge Clock);
        driveBoth(0, 32'h0, 1, 32'h100, 1, 1, 32'h200);
        @(posedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        checkVal("t6_rst.n_branches", bpBus.n_branches,    32'd0);
        checkVal("t6_rst.n_mispred",  bpBus.n_mispredicts, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        driveBoth(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        modelReset();
        step("t6_post80",  1, 32'h80,  0, 32'h0,  0, 0, 32'h0);
        step("t6_post100", 1, 32'h100, 0, 32'h0,  0, 0, 32'h0);
        step("t6_init",    0, 32'h0,   1, 32'h80, 0, 1, 32'hC0);
        step("t6_initlk",  1, 32'h80,  0, 32'h0,  0, 0, 32'h0);

        checkVal("queue_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
